// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 burst memory slave.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address stepper: next beat address, burst-level
// legality, window check and memory word index for the current beat.
module axi_burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [7:0]                     len,
    input  logic [2:0]                     size,
    input  logic [1:0]                     burst,
    output logic [ADDR_WIDTH-1:0]          next_addr,
    output logic                           burst_err,
    output logic                           in_range,
    output logic [$clog2(DEPTH_WORDS)-1:0] word_idx
);

    localparam int                    BUS_BYTES = DATA_WIDTH / 8;
    localparam int                    OFF_LSB   = $clog2(BUS_BYTES);
    localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [2:0]            MAX_SIZE  = 3'(OFF_LSB);
    localparam logic [ADDR_WIDTH-1:0] ONE       = 1;
    localparam logic [ADDR_WIDTH:0]   WIN_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * BUS_BYTES);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_bytes;
    logic [ADDR_WIDTH-1:0] wrap_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  wrap_len_ok;

    // Next-address arithmetic and legality for the beat at addr
    always_comb begin
        bytes      = ONE << size;
        aligned    = addr & ~(bytes - ONE);
        incr       = aligned + bytes;
        wrap_bytes = bytes * ({{(ADDR_WIDTH-8){1'b0}}, len} + ONE);
        wrap_base  = addr & ~(wrap_bytes - ONE);

        next_addr = addr;
        case (burst)
            INCR:    next_addr = incr;
            WRAP:    next_addr = (incr == wrap_base + wrap_bytes) ? wrap_base : incr;
            default: next_addr = addr;
        endcase

        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_err   = (size > MAX_SIZE) || (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok);

        offset   = addr - BASE_ADDR;
        in_range = (addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
        word_idx = offset[OFF_LSB +: IDX_W];
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs sharing one
// true-dual-port byte-enable memory (read-first on same-word collision).
module axi_burst_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    ID_WIDTH    = 1,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    axi_clk,
    input  logic                    reset,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int               BUS_BYTES = DATA_WIDTH / 8;
    localparam int               OFF_LSB   = $clog2(BUS_BYTES);
    localparam int               IDX_W     = $clog2(DEPTH_WORDS);
    localparam int               LANE_W    = OFF_LSB + 1;
    localparam logic [LANE_W-1:0] LONE     = 1;

    // Write channel state
    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [ID_WIDTH-1:0]   w_id;
    logic [8:0]            w_cnt;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_burst_err;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_beat_err;
    logic                  wr_en;
    logic [BUS_BYTES-1:0]  wr_be;
    logic [BUS_BYTES-1:0]  lane_ok;
    logic [LANE_W-1:0]     lane_bytes;
    logic [LANE_W-1:0]     lane_lo;
    logic [LANE_W-1:0]     lane_hi;

    // Read channel state
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_next;
    logic                  r_burst_err;
    logic                  r_in_range;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_beat_err;
    logic                  r_load;
    logic                  rd_en;
    logic                  rd_zero;
    logic [DATA_WIDTH-1:0] rd_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    axi_burst_addr_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_w_addr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next),
        .burst_err (w_burst_err),
        .in_range  (w_in_range),
        .word_idx  (w_idx)
    );

    axi_burst_addr_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_r_addr_gen (
        .addr      (r_addr),
        .len       (r_len),
        .size      (r_size),
        .burst     (r_burst),
        .next_addr (r_next),
        .burst_err (r_burst_err),
        .in_range  (r_in_range),
        .word_idx  (r_idx)
    );

    // Byte lanes belonging to this beat: from the address offset up to the
    // end of the size-aligned container (drops lanes below an unaligned start)
    always_comb begin
        lane_bytes = LONE << w_size;
        lane_lo    = {1'b0, w_addr[OFF_LSB-1:0]};
        lane_hi    = (lane_lo & ~(lane_bytes - LONE)) + lane_bytes;
        for (int unsigned i = 0; i < BUS_BYTES; i++) begin
            lane_ok[i] = (LANE_W'(i) >= lane_lo) && (LANE_W'(i) < lane_hi);
        end
        wr_be = s_axi_wstrb & lane_ok;

        w_beat_err = w_burst_err || !w_in_range || (w_cnt > {1'b0, w_len}) ||
                     (s_axi_wlast != (w_cnt == {1'b0, w_len}));
        wr_en = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready && !w_burst_err &&
                w_in_range && (w_cnt <= {1'b0, w_len});
    end

    // Read beat fetch: first beat when idle in R_DATA, next beat on each non-last handshake
    always_comb begin
        r_beat_err = r_burst_err || !r_in_range;
        r_load     = (r_state == R_DATA) && (!s_axi_rvalid || (s_axi_rready && !s_axi_rlast));
        rd_en      = r_load && !r_beat_err;
    end

    // Byte-enable write port
    always_ff @(posedge axi_clk) begin
        for (int unsigned i = 0; i < BUS_BYTES; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    // Registered read port; old data is returned on a same-edge write
    always_ff @(posedge axi_clk) begin
        if (rd_en) begin
            rd_q <= mem[r_idx];
        end
    end

    // Errored read beats present zero without touching the unreset BRAM register
    assign s_axi_rdata = rd_zero ? '0 : rd_q;

    // Write FSM: accept AW, absorb beats until wlast, then hold B until bready
    always_ff @(posedge axi_clk or posedge reset) begin
        if (reset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_id          <= '0;
            w_cnt         <= '0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid) begin
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_burst       <= s_axi_awburst;
                        w_id          <= s_axi_awid;
                        w_cnt         <= '0;
                        w_err         <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && s_axi_wready) begin
                        w_addr <= w_next;
                        if (w_cnt != 9'h100) begin
                            w_cnt <= w_cnt + 9'd1;
                        end
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            s_axi_bid    <= w_id;
                            w_state      <= W_RESP;
                        end else begin
                            w_err <= w_err || w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept AR, stream len+1 registered beats honouring rready
    always_ff @(posedge axi_clk or posedge reset) begin
        if (reset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            rd_zero       <= 1'b1;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_id          <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_burst       <= s_axi_arburst;
                        r_id          <= s_axi_arid;
                        r_cnt         <= '0;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_load) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rlast  <= (r_cnt == r_len);
                        s_axi_rresp  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rid    <= r_id;
                        rd_zero      <= r_beat_err;
                        r_addr       <= r_next;
                        r_cnt        <= r_cnt + 8'd1;
                    end else if (s_axi_rvalid && s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rlast  <= 1'b0;
                        r_state      <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave (32-bit data, 1024 words, base 0).
module tb_axi_burst_mem_slave;
    import axi_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awid = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        arid = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } r_exp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic       id;
    } b_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    int    n_checks = 0;
    int    n_pass   = 0;
    logic  rready_toggle = 1'b0;
    logic  stall_pend = 1'b0;
    logic  gap_pend = 1'b0;
    logic [31:0] held_data;
    logic [1:0]  held_resp;
    logic        held_last;

    always #5 clk = ~clk;

    axi_burst_mem_slave #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .ID_WIDTH    (1),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0)
    ) dut (
        .axi_clk       (clk),
        .reset         (rst),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic id);
        r_q.push_back('{data: d, resp: resp, last: last, id: id});
    endtask

    // Output monitor: pops expectations on handshakes, checks stall stability and gaps
    initial begin
        r_exp_t re;
        b_exp_t be;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_pend) begin
                    check("r_stall_valid", rvalid, 1'b1);
                    check("r_stall_data", rdata, held_data);
                    check("r_stall_resp", rresp, held_resp);
                    check("r_stall_last", rlast, held_last);
                    stall_pend = 1'b0;
                end
                if (gap_pend) begin
                    check("r_no_gap", rvalid, 1'b1);
                    gap_pend = 1'b0;
                end
                if (rvalid && !rready) begin
                    stall_pend = 1'b1;
                    held_data  = rdata;
                    held_resp  = rresp;
                    held_last  = rlast;
                end
                if (rvalid && rready) begin
                    if (r_q.size() == 0) begin
                        check("r_unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        re = r_q.pop_front();
                        check("r_data", rdata, re.data);
                        check("r_resp", rresp, re.resp);
                        check("r_last", rlast, re.last);
                        check("r_id", rid, re.id);
                        if (!rlast && !rready_toggle) gap_pend = 1'b1;
                    end
                end
                if (bvalid && bready) begin
                    if (b_q.size() == 0) begin
                        check("b_unexpected", 1'b1, 1'b0);
                    end else begin
                        be = b_q.pop_front();
                        check("b_resp", bresp, be.resp);
                        check("b_id", bid, be.id);
                    end
                end
            end
        end
    end

    // rready driver: held high, or toggled every cycle for backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rready = rready_toggle ? ~rready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int last_beat, input logic [1:0] exp_resp);
        int t;
        b_q.push_back('{resp: exp_resp, id: id});
        @(posedge clk);
        #1;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin @(negedge clk); t++; end
        check("aw_accept", awready, 1'b1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == last_beat);
            t = 0;
            @(negedge clk);
            while (!wready && t < 50) begin @(negedge clk); t++; end
            check("w_accept", wready, 1'b1);
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        t = 0;
        while (b_q.size() != 0 && t < 50) begin @(posedge clk); t++; end
        check("b_timeout", 64'(b_q.size()), 64'd0);
    endtask

    task automatic issue_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int t;
        @(posedge clk);
        #1;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin @(negedge clk); t++; end
        check("ar_accept", arready, 1'b1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("r_first_lat0", rvalid, 1'b0);
        @(negedge clk);
        check("r_first_lat1", rvalid, 1'b1);
    endtask

    task automatic drain_r();
        int t;
        t = 0;
        while (r_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
        check("r_timeout", 64'(r_q.size()), 64'd0);
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        issue_ar(id, addr, len, size, burst);
        drain_r();
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bid", bid, 1'b0);
        check("rst_rid", rid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_arready", arready, 1'b1);

        // Test 1: INCR write then read back
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        do_write(1'b0, 32'h100, 8'd3, 3'd2, INCR, 4, 3, RESP_OKAY);
        exp_r(32'h11111111, RESP_OKAY, 1'b0, 1'b1);
        exp_r(32'h22222222, RESP_OKAY, 1'b0, 1'b1);
        exp_r(32'h33333333, RESP_OKAY, 1'b0, 1'b1);
        exp_r(32'h44444444, RESP_OKAY, 1'b1, 1'b1);
        do_read(1'b1, 32'h100, 8'd3, 3'd2, INCR);

        // Test 2: WRAP 0x10C -> 0x100 -> 0x104 -> 0x108, then illegal len=2 WRAP
        exp_r(32'h44444444, RESP_OKAY, 1'b0, 1'b0);
        exp_r(32'h11111111, RESP_OKAY, 1'b0, 1'b0);
        exp_r(32'h22222222, RESP_OKAY, 1'b0, 1'b0);
        exp_r(32'h33333333, RESP_OKAY, 1'b1, 1'b0);
        do_read(1'b0, 32'h10C, 8'd3, 3'd2, WRAP);
        exp_r(32'h0, RESP_SLVERR, 1'b0, 1'b0);
        exp_r(32'h0, RESP_SLVERR, 1'b0, 1'b0);
        exp_r(32'h0, RESP_SLVERR, 1'b1, 1'b0);
        do_read(1'b0, 32'h100, 8'd2, 3'd2, WRAP);

        // Test 3: byte strobes
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
        do_write(1'b0, 32'h200, 8'd0, 3'd2, INCR, 1, 0, RESP_OKAY);
        wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
        do_write(1'b0, 32'h200, 8'd0, 3'd2, INCR, 1, 0, RESP_OKAY);
        exp_r(32'hAA22CC44, RESP_OKAY, 1'b1, 1'b0);
        do_read(1'b0, 32'h200, 8'd0, 3'd2, INCR);

        // Reserved burst type: SLVERR and memory untouched
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(1'b1, 32'h100, 8'd0, 3'd2, 2'b11, 1, 0, RESP_SLVERR);
        exp_r(32'h11111111, RESP_OKAY, 1'b1, 1'b0);
        do_read(1'b0, 32'h100, 8'd0, 3'd2, INCR);

        // Test 4: window edge with rready backpressure
        wbuf[0] = 32'h5555AAAA; wbuf[1] = 32'h12345678; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(1'b0, 32'hFF8, 8'd1, 3'd2, INCR, 2, 1, RESP_OKAY);
        rready_toggle = 1'b1;
        exp_r(32'h5555AAAA, RESP_OKAY, 1'b0, 1'b1);
        exp_r(32'h12345678, RESP_OKAY, 1'b0, 1'b1);
        exp_r(32'h0, RESP_SLVERR, 1'b0, 1'b1);
        exp_r(32'h0, RESP_SLVERR, 1'b1, 1'b1);
        do_read(1'b1, 32'hFF8, 8'd3, 3'd2, INCR);
        rready_toggle = 1'b0;

        // Test 5: early wlast, then missing wlast, then a legal write
        wbuf[0] = 32'h01010101; wbuf[1] = 32'h02020202; wbuf[2] = 32'h03030303;
        for (int i = 0; i < 3; i++) sbuf[i] = 4'hF;
        do_write(1'b1, 32'h400, 8'd3, 3'd2, INCR, 2, 1, RESP_SLVERR);
        @(negedge clk);
        @(negedge clk);
        check("w_idle_awready", awready, 1'b1);
        do_write(1'b0, 32'h500, 8'd1, 3'd2, INCR, 3, 2, RESP_SLVERR);
        wbuf[0] = 32'hCAFEF00D; sbuf[0] = 4'hF;
        do_write(1'b1, 32'h300, 8'd0, 3'd2, INCR, 1, 0, RESP_OKAY);
        exp_r(32'hCAFEF00D, RESP_OKAY, 1'b1, 1'b0);
        do_read(1'b0, 32'h300, 8'd0, 3'd2, INCR);

        // Test 6: reset during beat 2 of a len=7 read
        exp_r(32'h11111111, RESP_OKAY, 1'b0, 1'b0);
        exp_r(32'h22222222, RESP_OKAY, 1'b0, 1'b0);
        issue_ar(1'b0, 32'h100, 8'd7, 3'd2, INCR);
        drain_r();
        #1;
        rst = 1'b1;
        #1;
        check("abort_rvalid", rvalid, 1'b0);
        r_q.delete();
        stall_pend = 1'b0;
        gap_pend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_hold_rvalid", rvalid, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("release_arready", arready, 1'b1);
        check("release_awready", awready, 1'b1);
        check("release_rvalid", rvalid, 1'b0);
        exp_r(32'hCAFEF00D, RESP_OKAY, 1'b1, 1'b1);
        do_read(1'b1, 32'h300, 8'd0, 3'd2, INCR);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
